decoder_8b10b: RTL and testbench

Receive-side counterpart of `encoder_8b10b` in the PCIe physical layer. It takes one 10-bit symbol per valid cycle and produces the 8-bit byte and its K flag. It tracks running disparity (RD) and flags code and disparity errors. A small lock state machine, keyed on comma symbols, tells downstream logic when the symbol stream is trustworthy.

---
 rtl/pcie_8b10b_pkg.sv | 71 +++++++
 rtl/decoder_8b10b_lut.sv | 95 +++++++++
 rtl/decoder_8b10b.sv | 178 +++++++++++++++++
 tb/tb_decoder_8b10b.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pcie_8b10b_pkg.sv
// Shared 8b/10b definitions for the PCIe physical layer encoder and decoder:
// K code bytes, comma patterns, disparity/RD types and the lock FSM states.
package pcie_8b10b_pkg;

  typedef enum logic {
    RD_NEG = 1'b0,
    RD_POS = 1'b1
  } rd_e;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_CHECK    = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_e;

  typedef enum logic [1:0] {
    DISP_ZERO = 2'd0,
    DISP_POS  = 2'd1,
    DISP_NEG  = 2'd2
  } disp_e;

  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_1 = 8'h3C;
  localparam logic [7:0] K28_2 = 8'h5C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_4 = 8'h9C;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_6 = 8'hDC;
  localparam logic [7:0] K28_7 = 8'hFC;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K30_7 = 8'hFE;

  localparam logic [9:0] COMMA_K28_1_RDN = 10'h0F9;
  localparam logic [9:0] COMMA_K28_1_RDP = 10'h306;
  localparam logic [9:0] COMMA_K28_5_RDN = 10'h0FA;
  localparam logic [9:0] COMMA_K28_5_RDP = 10'h305;
  localparam logic [9:0] COMMA_K28_7_RDN = 10'h0F8;
  localparam logic [9:0] COMMA_K28_7_RDP = 10'h307;

  // 6b sub-blocks that only ever occur as part of K28.y
  localparam logic [5:0] SB6_K28_RDN = 6'b001111;
  localparam logic [5:0] SB6_K28_RDP = 6'b110000;

  function automatic logic is_comma(input logic [7:0] b);
    return (b == K28_1) || (b == K28_5) || (b == K28_7);
  endfunction

  // Out-of-table sub-blocks still report the sign of their imbalance.
  function automatic disp_e disp_of6(input logic [5:0] sb);
    int unsigned ones;
    ones = $countones(sb);
    if (ones > 32'd3) return DISP_POS;
    if (ones < 32'd3) return DISP_NEG;
    return DISP_ZERO;
  endfunction

  function automatic disp_e disp_of4(input logic [3:0] sb);
    int unsigned ones;
    ones = $countones(sb);
    if (ones > 32'd2) return DISP_POS;
    if (ones < 32'd2) return DISP_NEG;
    return DISP_ZERO;
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/decoder_8b10b_lut.sv
// Combinational 6b->5b and 4b->3b lookup for one 10-bit symbol {abcdei,fghj}.
module decoder_8b10b_lut
  import pcie_8b10b_pkg::*;
(
  input  logic [9:0] symbol_i,
  output logic [4:0] dec5_o,
  output logic       valid6_o,
  output disp_e      disp6_o,
  output logic       k6_o,
  output logic [2:0] dec3_o,
  output logic       valid4_o,
  output disp_e      disp4_o,
  output logic       k4_o
);

  logic [5:0] sb6;
  logic [3:0] sb4;
  logic [3:0] sb4_lu;

  assign sb6 = symbol_i[9:4];
  assign sb4 = symbol_i[3:0];
  // K28.y at RD+ is the bitwise complement of its RD- form, so the neutral
  // 4b codes must be looked up inverted to recover y.
  assign sb4_lu = (sb6 == SB6_K28_RDP) ? ~sb4 : sb4;

  assign disp6_o = disp_of6(sb6);
  assign disp4_o = disp_of4(sb4);

  always_comb begin
    dec5_o   = '0;
    valid6_o = 1'b1;
    k6_o     = 1'b0;
    case (sb6)
      6'b100111, 6'b011000: dec5_o = 5'd0;
      6'b011101, 6'b100010: dec5_o = 5'd1;
      6'b101101, 6'b010010: dec5_o = 5'd2;
      6'b110001:            dec5_o = 5'd3;
      6'b110101, 6'b001010: dec5_o = 5'd4;
      6'b101001:            dec5_o = 5'd5;
      6'b011001:            dec5_o = 5'd6;
      6'b111000, 6'b000111: dec5_o = 5'd7;
      6'b111001, 6'b000110: dec5_o = 5'd8;
      6'b100101:            dec5_o = 5'd9;
      6'b010101:            dec5_o = 5'd10;
      6'b110100:            dec5_o = 5'd11;
      6'b001101:            dec5_o = 5'd12;
      6'b101100:            dec5_o = 5'd13;
      6'b011100:            dec5_o = 5'd14;
      6'b010111, 6'b101000: dec5_o = 5'd15;
      6'b011011, 6'b100100: dec5_o = 5'd16;
      6'b100011:            dec5_o = 5'd17;
      6'b010011:            dec5_o = 5'd18;
      6'b110010:            dec5_o = 5'd19;
      6'b001011:            dec5_o = 5'd20;
      6'b101010:            dec5_o = 5'd21;
      6'b011010:            dec5_o = 5'd22;
      6'b111010, 6'b000101: dec5_o = 5'd23;
      6'b110011, 6'b001100: dec5_o = 5'd24;
      6'b100110:            dec5_o = 5'd25;
      6'b010110:            dec5_o = 5'd26;
      6'b110110, 6'b001001: dec5_o = 5'd27;
      6'b001110:            dec5_o = 5'd28;
      6'b101110, 6'b010001: dec5_o = 5'd29;
      6'b011110, 6'b100001: dec5_o = 5'd30;
      6'b101011, 6'b010100: dec5_o = 5'd31;
      6'b001111, 6'b110000: begin
        dec5_o = 5'd28;
        k6_o   = 1'b1;
      end
      default: valid6_o = 1'b0;
    endcase
  end

  always_comb begin
    dec3_o   = '0;
    valid4_o = 1'b1;
    k4_o     = 1'b0;
    case (sb4_lu)
      4'b1011, 4'b0100: dec3_o = 3'd0;
      4'b1001:          dec3_o = 3'd1;
      4'b0101:          dec3_o = 3'd2;
      4'b1100, 4'b0011: dec3_o = 3'd3;
      4'b1101, 4'b0010: dec3_o = 3'd4;
      4'b1010:          dec3_o = 3'd5;
      4'b0110:          dec3_o = 3'd6;
      4'b1110, 4'b0001: dec3_o = 3'd7;
      4'b0111, 4'b1000: begin
        dec3_o = 3'd7;
        k4_o   = 1'b1;
      end
      default: valid4_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/decoder_8b10b.sv
// 8b/10b receive decoder: table lookup, running-disparity tracking, code and
// disparity error flags, and a comma-keyed symbol lock state machine.
module decoder_8b10b
  import pcie_8b10b_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned ERR_LIMIT  = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [9:0] symbol_i,
  input  logic       symbol_valid_i,
  output logic [7:0] data_o,
  output logic       is_special_k_o,
  output logic       data_valid_o,
  output logic       code_err_o,
  output logic       disp_err_o,
  output logic       rd_o,
  output logic       locked_o
);

  localparam logic [3:0] LOCK_CNT4 = 4'(LOCK_COUNT);
  localparam logic [3:0] ERR_LIM4  = 4'(ERR_LIMIT);

  logic [4:0] dec5;
  logic       valid6;
  disp_e      disp6;
  logic       k6;
  logic [2:0] dec3;
  logic       valid4;
  disp_e      disp4;
  logic       k4;

  decoder_8b10b_lut u_lut (
    .symbol_i (symbol_i),
    .dec5_o   (dec5),
    .valid6_o (valid6),
    .disp6_o  (disp6),
    .k6_o     (k6),
    .dec3_o   (dec3),
    .valid4_o (valid4),
    .disp4_o  (disp4),
    .k4_o     (k4)
  );

  rd_e         rd_q, rd_d, rd_mid;
  logic [7:0]  data_q, data_d;
  logic        k_q, k_d;
  logic        code_err_q, code_err_d;
  logic        disp_err_q, disp_err_d;
  logic        valid_q;
  lock_state_e state_q, state_d;
  logic [3:0]  good_q, good_d;
  logic [3:0]  bad_q, bad_d;

  logic k_cand;
  logic pair_err;
  logic any_err;
  logic comma;

  always_comb begin
    disp_err_d = 1'b0;
    rd_mid     = rd_q;
    if (disp6 == DISP_POS) begin
      disp_err_d = (rd_q == RD_POS);
      rd_mid     = RD_POS;
    end else if (disp6 == DISP_NEG) begin
      disp_err_d = (rd_q == RD_NEG);
      rd_mid     = RD_NEG;
    end

    rd_d = rd_mid;
    if (disp4 == DISP_POS) begin
      disp_err_d = disp_err_d | (rd_mid == RD_POS);
      rd_d       = RD_POS;
    end else if (disp4 == DISP_NEG) begin
      disp_err_d = disp_err_d | (rd_mid == RD_NEG);
      rd_d       = RD_NEG;
    end
  end

  // The A7 4b code is legal only as Kx.7 (x = 23,27,29,30) or as the
  // run-length-limiting Dx.7 for x = 11,13,14,17,18,20.
  always_comb begin
    k_cand   = 1'b0;
    pair_err = 1'b0;
    if (k6) begin
      k_cand = 1'b1;
    end else if (k4) begin
      if (dec5 inside {5'd23, 5'd27, 5'd29, 5'd30}) begin
        k_cand = 1'b1;
      end else if (!(dec5 inside {5'd11, 5'd13, 5'd14, 5'd17, 5'd18, 5'd20})) begin
        pair_err = 1'b1;
      end
    end
    code_err_d = !valid6 || !valid4 || pair_err;
    any_err    = code_err_d || disp_err_d;
    k_d        = k_cand && !any_err;
    data_d     = {dec3, dec5};
    comma      = k_d && is_comma(data_d);
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    if (symbol_valid_i) begin
      case (state_q)
        ST_UNLOCKED: begin
          if (comma) begin
            state_d = ST_CHECK;
            good_d  = '0;
          end
        end
        ST_CHECK: begin
          if (any_err) begin
            state_d = ST_UNLOCKED;
            good_d  = '0;
          end else begin
            good_d = sat_inc4(good_q);
            if (good_d >= LOCK_CNT4) begin
              state_d = ST_LOCKED;
              bad_d   = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (any_err) begin
            bad_d = sat_inc4(bad_q);
            if (bad_d >= ERR_LIM4) begin
              state_d = ST_UNLOCKED;
              bad_d   = '0;
              good_d  = '0;
            end
          end else begin
            bad_d = '0;
          end
        end
        default: state_d = ST_UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_q       <= RD_NEG;
      data_q     <= '0;
      k_q        <= 1'b0;
      code_err_q <= 1'b0;
      disp_err_q <= 1'b0;
      valid_q    <= 1'b0;
      state_q    <= ST_UNLOCKED;
      good_q     <= '0;
      bad_q      <= '0;
    end else begin
      valid_q <= symbol_valid_i;
      state_q <= state_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      if (symbol_valid_i) begin
        rd_q       <= rd_d;
        data_q     <= data_d;
        k_q        <= k_d;
        code_err_q <= code_err_d;
        disp_err_q <= disp_err_d;
      end
    end
  end

  assign data_o         = data_q;
  assign is_special_k_o = k_q;
  assign data_valid_o   = valid_q;
  assign code_err_o     = code_err_q;
  assign disp_err_o     = disp_err_q;
  assign rd_o           = (rd_q == RD_POS);
  assign locked_o       = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_decoder_8b10b.sv
// Scoreboard bench for decoder_8b10b: directed symbols plus an encoder-model
// loopback, checked by a monitor that pops expectations on data_valid_o.
module tb_decoder_8b10b;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic [9:0] symbol_i = '0;
  logic       symbol_valid_i = 1'b0;
  logic [7:0] data_o;
  logic       is_special_k_o;
  logic       data_valid_o;
  logic       code_err_o;
  logic       disp_err_o;
  logic       rd_o;
  logic       locked_o;

  decoder_8b10b #(
    .LOCK_COUNT(4),
    .ERR_LIMIT (4)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .symbol_i       (symbol_i),
    .symbol_valid_i (symbol_valid_i),
    .data_o         (data_o),
    .is_special_k_o (is_special_k_o),
    .data_valid_o   (data_valid_o),
    .code_err_o     (code_err_o),
    .disp_err_o     (disp_err_o),
    .rd_o           (rd_o),
    .locked_o       (locked_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0] data;
    logic       k;
    logic       code;
    logic       disp;
    logic       rd;
    logic       locked;
    logic       chk_data;
  } exp_t;

  exp_t        sb_q[$];
  string       name_q[$];
  exp_t        last_exp = '0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  // RD- forms of the 5b/6b and 3b/4b data codes, indexed by x and y.
  localparam logic [5:0] T6 [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [3:0] T4 [8] = '{
    4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};

  function automatic logic [10:0] enc(input logic [7:0] b, input logic rd_in);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       rd;
    x  = b[4:0];
    y  = b[7:5];
    rd = rd_in;
    c6 = T6[x];
    if (rd && ($countones(c6) != 3 || x == 5'd7)) c6 = ~c6;
    if ($countones(c6) > 3) rd = 1'b1;
    else if ($countones(c6) < 3) rd = 1'b0;
    if (y == 3'd7 && ((!rd && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                      (rd && (x == 5'd11 || x == 5'd13 || x == 5'd14)))) begin
      c4 = rd ? 4'b1000 : 4'b0111;
    end else begin
      c4 = T4[y];
      if (rd && ($countones(c4) != 2 || y == 3'd3)) c4 = ~c4;
    end
    if ($countones(c4) > 2) rd = 1'b1;
    else if ($countones(c4) < 2) rd = 1'b0;
    return {rd, c6, c4};
  endfunction

  function automatic exp_t E(input logic [7:0] d, input logic k, input logic code,
                             input logic disp, input logic rd, input logic locked,
                             input logic chk_data = 1'b1);
    exp_t e;
    e.data = d; e.k = k; e.code = code; e.disp = disp;
    e.rd = rd; e.locked = locked; e.chk_data = chk_data;
    return e;
  endfunction

  task automatic check(input string nm, input exp_t e);
    n_checks++;
    if ((!e.chk_data || data_o === e.data) && is_special_k_o === e.k &&
        code_err_o === e.code && disp_err_o === e.disp &&
        rd_o === e.rd && locked_o === e.locked) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got data=%02h k=%b code=%b disp=%b rd=%b locked=%b, expected data=%02h k=%b code=%b disp=%b rd=%b locked=%b",
               nm, data_o, is_special_k_o, code_err_o, disp_err_o, rd_o, locked_o,
               e.data, e.k, e.code, e.disp, e.rd, e.locked);
    end
  endtask

  task automatic check_bit(input string nm, input logic act, input logic exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %b, expected %b", nm, act, exp_v);
  endtask

  // Monitor: pops one expectation per presented symbol; otherwise outputs must hold.
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (data_valid_o) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: got data=%02h with empty scoreboard", data_o);
        end else begin
          last_exp = sb_q.pop_front();
          check(name_q.pop_front(), last_exp);
        end
      end else begin
        check("hold", last_exp);
      end
    end
  end

  task automatic send(input logic [9:0] sym, input string nm, input exp_t e);
    @(posedge clk_i);
    #1;
    symbol_i       = sym;
    symbol_valid_i = 1'b1;
    sb_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic idle();
    @(posedge clk_i);
    #1;
    symbol_i       = 10'h3FF;
    symbol_valid_i = 1'b0;
  endtask

  initial begin
    logic        enc_rd;
    logic [10:0] r;
    logic [9:0]  sym;

    repeat (3) @(posedge clk_i);
    #2;
    check("reset_values", '0);
    check_bit("reset_valid", data_valid_o, 1'b0);
    @(posedge clk_i);
    #1 reset_i = 1'b0;

    send(10'h0FA, "k28_5_rdn", E(8'hBC, 1, 0, 0, 1, 0));
    for (int i = 0; i < 4; i++) send(10'h2AA, "d21_5_lock", E(8'hB5, 0, 0, 0, 1, i == 3));

    send(10'h18B, "d0_0_rdp", E(8'h00, 0, 0, 0, 1, 1));
    send(10'h0FA, "k28_5_wrong_rd", E(8'hBC, 0, 0, 1, 1, 1));
    idle();
    idle();
    send(10'h2AA, "clean_after_disp", E(8'hB5, 0, 0, 0, 1, 1));

    for (int i = 0; i < 3; i++) send(10'h3FF, "bad_sym", E(8'h00, 0, 1, 1, 1, 1, 0));
    send(10'h2AA, "clean_between", E(8'hB5, 0, 0, 0, 1, 1));
    for (int i = 0; i < 4; i++) send(10'h3FF, "bad_sym_drop", E(8'h00, 0, 1, 1, 1, i < 3, 0));

    send(10'h187, "a7_bad_pairing", E(8'hE0, 0, 1, 0, 1, 0));
    send(10'h057, "k23_7_rdp", E(8'hF7, 1, 0, 0, 1, 0));
    send(10'h2AB, "disp_err_4b", E(8'h15, 0, 0, 1, 1, 0));
    send(10'h305, "k28_5_rdp", E(8'hBC, 1, 0, 0, 0, 0));

    enc_rd = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int b = 0; b < 256; b++) begin
        r      = enc(8'(b), enc_rd);
        enc_rd = r[10];
        sym    = r[9:0];
        send(sym, "loopback", E(8'(b), 0, 0, 0, enc_rd, (pass == 1) || (b >= 3)));
        if (b % 61 == 60) idle();
      end
    end

    idle();
    @(negedge clk_i);
    #2 reset_i = 1'b1;
    #1;
    check("midstream_reset", '0);
    check_bit("midstream_reset_valid", data_valid_o, 1'b0);
    last_exp = '0;
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;

    send(10'h0FA, "after_reset_k28_5", E(8'hBC, 1, 0, 0, 1, 0));
    send(10'h306, "k28_1_rdp", E(8'h3C, 1, 0, 0, 0, 0));
    idle();

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk_i);
    @(negedge clk_i);
    check_bit("scoreboard_drained", sb_q.size() == 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
